hack_sequencer: RTL

Fetch/execute sequencer for the Hack CPU datapath. It fetches each instruction from instruction memory and performs the data-memory read for M operands. It then pulses the datapath's latch enable for exactly one execute cycle and performs the data-memory write for M destinations. It sits between the datapath (`main`) and two req/ack memory ports, and provides run/halt/single-step control plus a retired-instruction counter.

---
 rtl/hack_mem_if.sv | 24 ++
 rtl/hack_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/hack_mem_if.sv
// Instruction and data memory ports of the Hack sequencer, bundled as one interface.
// Req/ack: a request holds with address/data stable until the cycle its ack is sampled high; ack may arrive in the first request cycle and is ignored while the request is low.
interface hack_mem_if;
   logic        ireq_o;
   logic [15:0] iaddr_o;
   logic        iack_i;
   logic [15:0] irdata_i;
   logic        dreq_o;
   logic        dwe_o;
   logic [15:0] daddr_o;
   logic [15:0] dwdata_o;
   logic        dack_i;
   logic [15:0] drdata_i;

   modport master (
      output ireq_o, iaddr_o, dreq_o, dwe_o, daddr_o, dwdata_o,
      input  iack_i, irdata_i, dack_i, drdata_i
   );

   modport slave (
      input  ireq_o, iaddr_o, dreq_o, dwe_o, daddr_o, dwdata_o,
      output iack_i, irdata_i, dack_i, drdata_i
   );
endinterface

// File: rtl/hack_sequencer.sv
// Fetch/execute sequencer for the Hack datapath: fetch, optional M read, one-cycle
// execute (enLatch), optional M write, with run/step/halt control and a retire counter.
module hack_sequencer (
   input  logic        clk,
   input  logic        resetb,
   input  logic        start_i,
   input  logic        step_i,
   input  logic        halt_req_i,
   input  logic [15:0] pc_i,
   input  logic [15:0] addressM_i,
   input  logic [15:0] outM_i,
   output logic [15:0] instr_o,
   output logic [15:0] inM_o,
   output logic        enLatch_o,
   output logic        halt_o,
   output logic        running_o,
   output logic        illegal_o,
   output logic [15:0] retired_o,
   output logic [2:0]  dbg_state_o,
   hack_mem_if.master  mem
);

   typedef enum logic [2:0] {
      HALTED = 3'd0,
      FETCH  = 3'd1,
      READ   = 3'd2,
      EXEC   = 3'd3,
      WRITE  = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic        step_q, step_d;
   logic        halt_pend_q, halt_pend_d;
   logic        illegal_q, illegal_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] inm_q, inm_d;
   logic [15:0] daddr_q, daddr_d;
   logic [15:0] dwdata_q, dwdata_d;
   logic [15:0] retired_q, retired_d;
   logic        retire;
   logic        ireq, dreq, dwe;

   logic fetch_is_c, fetch_illegal, fetch_uses_m, exec_writes_m;
   assign fetch_is_c    = (mem.irdata_i[15:13] == 3'b111);
   assign fetch_illegal = mem.irdata_i[15] && (mem.irdata_i[14:13] != 2'b11);
   assign fetch_uses_m  = fetch_is_c && mem.irdata_i[12];
   assign exec_writes_m = (instr_q[15:13] == 3'b111) && instr_q[3];

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q     <= HALTED;
         step_q      <= 1'b0;
         halt_pend_q <= 1'b0;
         illegal_q   <= 1'b0;
         instr_q     <= 16'h0000;
         inm_q       <= 16'h0000;
         daddr_q     <= 16'h0000;
         dwdata_q    <= 16'h0000;
         retired_q   <= 16'h0000;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         halt_pend_q <= halt_pend_d;
         illegal_q   <= illegal_d;
         instr_q     <= instr_d;
         inm_q       <= inm_d;
         daddr_q     <= daddr_d;
         dwdata_q    <= dwdata_d;
         retired_q   <= retired_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      halt_pend_d = halt_pend_q;
      illegal_d   = illegal_q;
      instr_d     = instr_q;
      inm_d       = inm_q;
      daddr_d     = daddr_q;
      dwdata_d    = dwdata_q;
      retired_d   = retired_q;
      retire      = 1'b0;
      ireq        = 1'b0;
      dreq        = 1'b0;
      dwe         = 1'b0;

      // A halt request seen in the retiring cycle itself still stops the run.
      if (halt_req_i && (state_q != HALTED)) halt_pend_d = 1'b1;

      case (state_q)
         HALTED: begin
            if (halt_req_i) begin
               state_d = HALTED;
            end else if (start_i) begin
               state_d   = FETCH;
               step_d    = 1'b0;
               illegal_d = 1'b0;
            end else if (step_i) begin
               state_d   = FETCH;
               step_d    = 1'b1;
               illegal_d = 1'b0;
            end
         end
         FETCH: begin
            ireq = 1'b1;
            if (mem.iack_i) begin
               instr_d = mem.irdata_i;
               if (fetch_illegal) begin
                  state_d   = HALTED;
                  illegal_d = 1'b1;
               end else if (fetch_uses_m) begin
                  daddr_d = addressM_i;
                  state_d = READ;
               end else begin
                  state_d = EXEC;
               end
            end
         end
         READ: begin
            dreq = 1'b1;
            if (mem.dack_i) begin
               inm_d   = mem.drdata_i;
               state_d = EXEC;
            end
         end
         EXEC: begin
            // addressM/outM are sampled on the same edge A updates, so AM writes the old A.
            if (exec_writes_m) begin
               daddr_d  = addressM_i;
               dwdata_d = outM_i;
               state_d  = WRITE;
            end else begin
               retire = 1'b1;
            end
         end
         WRITE: begin
            dreq = 1'b1;
            dwe  = 1'b1;
            if (mem.dack_i) retire = 1'b1;
         end
         default: state_d = HALTED;
      endcase

      if (retire) begin
         retired_d = retired_q + 16'd1;
         state_d   = (halt_pend_d || step_q) ? HALTED : FETCH;
      end

      if (state_d == HALTED) halt_pend_d = 1'b0;
   end

   assign instr_o      = instr_q;
   assign inM_o        = inm_q;
   assign enLatch_o    = (state_q == EXEC);
   assign halt_o       = (state_q != EXEC);
   assign running_o    = (state_q != HALTED);
   assign illegal_o    = illegal_q;
   assign retired_o    = retired_q;
   assign dbg_state_o  = state_q;

   assign mem.ireq_o   = ireq;
   assign mem.iaddr_o  = pc_i;
   assign mem.dreq_o   = dreq;
   assign mem.dwe_o    = dwe;
   assign mem.daddr_o  = daddr_q;
   assign mem.dwdata_o = dwdata_q;

endmodule
